aes_inv_cipher_iter: RTL and testbench

//  Iterative AES decryption engine (FIPS-197 InverseCipher) for the receive side of the AES path.

---
 rtl/aes_inv_cipher_iter_pkg.sv | 53 +++++
 rtl/aes_inv_cipher_iter_round.sv | 36 +++
 rtl/aes_inv_cipher_iter.sv | 115 +++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_inv_cipher_iter_pkg.sv
// Shared definitions for the iterative AES inverse cipher.
//   - NB: state width in 32-bit columns
//   - state_e: controller states
//   - inv_sbox(): AES inverse S-box lookup
//   - xtime()/gmul(): GF(2^8) helpers, modulus x^8+x^4+x^3+x+1
package aes_inv_cipher_iter_pkg;

  localparam int NB = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_DONE
  } state_e;

  // Inverse S-box; entry 0 sits in the top byte.
  localparam logic [2047:0] INV_SBOX_FLAT = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_FLAT[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant; InvMixColumns only needs 09/0b/0d/0e.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{k[0]}} & a) ^ ({8{k[1]}} & x2) ^ ({8{k[2]}} & x4) ^ ({8{k[3]}} & x8);
  endfunction

endpackage

// File: rtl/aes_inv_cipher_iter_round.sv
// One AES inverse round, purely combinational.
//   state_in  : 128-bit state, byte 0 in [127:120], column-major
//   rk        : round key for this round
//   last      : skip InvMixColumns (final round, rk[0])
//   state_out : InvMixColumns?(AddRoundKey(InvSubBytes(InvShiftRows(state_in)), rk))
module aes_inv_cipher_iter_round
  import aes_inv_cipher_iter_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] state_out
);

  logic [7:0] w_col [4];

  // NOTE: every output of an always_comb gets a default before any
  // conditional logic so no path can leave it unassigned (no latch).
  always_comb begin
    state_out = '0;
    for (int i = 0; i < 4; i++) w_col[i] = '0;
    for (int c = 0; c < NB; c++) begin
      // Row r of column c comes from column (c - r) mod 4 after InvShiftRows.
      for (int r = 0; r < 4; r++) begin
        w_col[r] = inv_sbox(state_in[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8])
                 ^ rk[127 - 8*(r + 4*c) -: 8];
      end
      for (int r = 0; r < 4; r++) begin
        state_out[127 - 8*(r + 4*c) -: 8] = last ? w_col[r] :
            gmul(w_col[r], 4'he)           ^ gmul(w_col[(r + 1) % 4], 4'hb) ^
            gmul(w_col[(r + 2) % 4], 4'hd) ^ gmul(w_col[(r + 3) % 4], 4'h9);
      end
    end
  end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES decryption engine: one inverse round per clock.
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   in_valid   : ciphertext + key schedule offered
//   in_ready   : engine can accept this cycle (combinational)
//   in_data    : ciphertext, byte 0 in [127:120]
//   key_sched  : round keys, round r at [128*(Nr+1)-1-128*r -: 128]
//   out_valid  : plaintext available (registered)
//   out_ready  : downstream accepts plaintext
//   out_data   : plaintext, held until the output handshake
module aes_inv_cipher_iter
  import aes_inv_cipher_iter_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [127:0]          in_data,
  input  logic [128*(Nr+1)-1:0] key_sched,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          out_data
);

  if (Nr != Nk + 6) begin : g_bad_rounds
    $error("aes_inv_cipher_iter: Nr=%0d must equal Nk+6=%0d", Nr, Nk + 6);
  end

  localparam int KW = 128*(Nr+1);

  state_e          r_state;
  state_e          w_next_state;
  logic [127:0]    r_data;
  logic [127:0]    r_out_data;
  logic [KW-1:0]   r_keys;
  logic [3:0]      r_rnd;
  logic            r_out_valid;
  logic            w_accept;
  logic            w_last;
  logic [127:0]    w_rk;
  logic [127:0]    w_round_out;

  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_rnd == 4'd0);
  // Round r lives 128*(Nr-r) bits up from bit 0 of the captured schedule.
  assign w_rk     = r_keys[128*(Nr - int'(r_rnd)) +: 128];

  aes_inv_cipher_iter_round u_round (
    .state_in  (r_data),
    .rk        (w_rk),
    .last      (w_last),
    .state_out (w_round_out)
  );

  // NOTE: sequential state is written with non-blocking assignments only,
  // so every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:  if (in_valid) w_next_state = ST_ROUND;
      ST_ROUND: if (w_last)   w_next_state = ST_DONE;
      ST_DONE:  if (out_ready) w_next_state = in_valid ? ST_ROUND : ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // in_ready depends only on state and out_ready, never on in_valid.
  always_comb begin
    in_ready = 1'b0;
    unique case (r_state)
      ST_IDLE: in_ready = 1'b1;
      ST_DONE: in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  // NOTE: the wide key register is reset as well: a reset must leave no key
  // material behind, which outweighs the cost of resettable flops here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data      <= '0;
      r_keys      <= '0;
      r_rnd       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_accept) begin
      // Initial AddRoundKey with rk[Nr], which sits in the low 128 bits.
      r_data      <= in_data ^ key_sched[127:0];
      r_keys      <= key_sched;
      r_rnd       <= 4'(Nr - 1);
      r_out_valid <= 1'b0;
    end else if (r_state == ST_ROUND) begin
      r_data <= w_round_out;
      if (w_last) begin
        r_out_data  <= w_round_out;
        r_out_valid <= 1'b1;
      end else begin
        r_rnd <= r_rnd - 4'd1;
      end
    end else if (r_state == ST_DONE && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
module tb_aes_inv_cipher_iter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]        in_valid_v;
  wire  [2:0]        in_ready_v;
  wire  [2:0]        out_valid_v;
  wire  [127:0]      od0, od1, od2;
  logic [127:0]      in_data;
  logic [15*128-1:0] ks_bus;
  logic              out_ready;

  int total = 0;
  int bad   = 0;

  logic [7:0] sbox_t  [256];
  logic [7:0] isbox_t [256];

  localparam logic [255:0] K1   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] C1   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P1   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] K4   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] C4   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PSTD = 128'h00112233445566778899aabbccddeeff;

  aes_inv_cipher_iter #(.Nk(4), .Nr(10)) u128 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_data(in_data), .key_sched(ks_bus[1919 -: 1408]), .out_valid(out_valid_v[0]),
    .out_ready(out_ready), .out_data(od0));

  aes_inv_cipher_iter #(.Nk(6), .Nr(12)) u192 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_data(in_data), .key_sched(ks_bus[1919 -: 1664]), .out_valid(out_valid_v[1]),
    .out_ready(out_ready), .out_data(od1));

  aes_inv_cipher_iter #(.Nk(8), .Nr(14)) u256 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_data(in_data), .key_sched(ks_bus), .out_valid(out_valid_v[2]),
    .out_ready(out_ready), .out_data(od2));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] od(input int s);
    case (s)
      0:       return od0;
      1:       return od1;
      default: return od2;
    endcase
  endfunction

  // ---------------- reference model (FIPS-197 on byte arrays) ----------------
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // S-box = affine transform of the multiplicative inverse; inverse table by inversion.
  task automatic build_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_t[x]  = s;
      isbox_t[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // Key expansion into a 15-round bus, round 0 at the top.
  function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] ks;
    int            nwords;
    rc = 8'h01;
    ks = '0;
    nwords = 4 * (nk + 7);
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < nwords; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < nwords; i++) ks[1919 - 32*i -: 32] = w[i];
    return ks;
  endfunction

  function automatic logic [127:0] ref_dec(input logic [127:0] ct, input logic [1919:0] ks, input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] m [4][4];
    logic [127:0] res;
    m = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09}, '{8'h09, 8'h0e, 8'h0b, 8'h0d},
          '{8'h0d, 8'h09, 8'h0e, 8'h0b}, '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
    for (int i = 0; i < 16; i++) s[i] = ct[127 - 8*i -: 8] ^ ks[1919 - 128*nr - 8*i -: 8];
    for (int rd = nr - 1; rd >= 0; rd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r + 4*c] = s[r + 4*((c + 4 - r) % 4)];
      for (int i = 0; i < 16; i++) s[i] = isbox_t[t[i]] ^ ks[1919 - 128*rd - 8*i -: 8];
      if (rd != 0) begin
        for (int i = 0; i < 16; i++) t[i] = s[i];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) begin
            s[r + 4*c] = 8'h00;
            for (int k = 0; k < 4; k++) s[r + 4*c] ^= gm(m[r][k], t[k + 4*c]);
          end
      end
    end
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- stimulus helpers ----------------
  // Enter and leave at a falling edge with the chosen engine idle.
  task automatic run_block(input int sel, input logic [127:0] ct, input logic [255:0] key,
                           input int stall, input logic [127:0] exp, input string tag);
    int nr;
    int edges;
    nr = 10 + 2*sel;
    check({tag, "_rdy_idle"}, 128'(in_ready_v[sel]), 128'd1);
    ks_bus     = expand(key, 4 + 2*sel);
    in_data    = ct;
    in_valid_v = 3'(1 << sel);
    out_ready  = 1'b0;
    @(negedge clk);
    in_valid_v = 3'b000;
    edges = 1;
    check({tag, "_rdy_busy"}, 128'(in_ready_v[sel]), 128'd0);
    while (!out_valid_v[sel] && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    check({tag, "_latency"}, 128'(edges), 128'(nr + 1));
    check({tag, "_data"}, od(sel), exp);
    repeat (stall) @(negedge clk);
    check({tag, "_hold"}, od(sel), exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_ov_drop"}, 128'(out_valid_v[sel]), 128'd0);
  endtask

  initial begin
    logic [255:0]  rkey;
    logic [127:0]  rct;
    logic [1919:0] rks;
    int edges;

    rst = 1'b1;
    in_valid_v = 3'b000;
    in_data = '0;
    ks_bus = '0;
    out_ready = 1'b0;
    build_tables();
    repeat (2) @(negedge clk);
    check("reset_in_ready", 128'(in_ready_v[0]), 128'd1);
    check("reset_out_valid", 128'(out_valid_v[0]), 128'd0);
    check("reset_out_data", od0, 128'd0);
    rst = 1'b0;
    @(negedge clk);

    // T1..T3: known-answer vectors for each key size
    run_block(0, C1, K1, 0, P1, "t1_aes128");
    run_block(1, C192, K192, 1, PSTD, "t2_aes192");
    run_block(2, C256, K256, 2, PSTD, "t3_aes256");

    // T4: backpressure, then back-to-back accept on the release edge
    ks_bus = expand(K1, 4); in_data = C1; in_valid_v = 3'b001; out_ready = 1'b0;
    @(negedge clk);
    in_valid_v = 3'b000;
    edges = 1;
    while (!out_valid_v[0] && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    check("t4_first_latency", 128'(edges), 128'd11);
    ks_bus = expand(K4, 4); in_data = C4; in_valid_v = 3'b001;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t4_stall_data", od0, P1);
      check("t4_stall_rdy", 128'(in_ready_v[0]), 128'd0);
    end
    check("t4_stall_ov", 128'(out_valid_v[0]), 128'd1);
    out_ready = 1'b1;
    #1 check("t4_rdy_follows_out_ready", 128'(in_ready_v[0]), 128'd1);
    @(negedge clk);
    out_ready = 1'b0; in_valid_v = 3'b000;
    edges = 1;
    check("t4_ov_after_accept", 128'(out_valid_v[0]), 128'd0);
    while (!out_valid_v[0] && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    check("t4_second_latency", 128'(edges), 128'd11);
    check("t4_second_data", od0, PSTD);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // T5: inputs scrambled right after the accept edge
    ks_bus = expand(K1, 4); in_data = C1; in_valid_v = 3'b001;
    @(negedge clk);
    in_valid_v = 3'b000;
    in_data = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 60; i++) ks_bus[32*i +: 32] = $urandom;
    edges = 1;
    while (!out_valid_v[0] && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    check("t5_data", od0, P1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // T6: reset while rnd == 5, then a clean rerun
    ks_bus = expand(K1, 4); in_data = C1; in_valid_v = 3'b001;
    @(negedge clk);
    in_valid_v = 3'b000;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rst_out_valid", 128'(out_valid_v[0]), 128'd0);
    check("t6_rst_in_ready", 128'(in_ready_v[0]), 128'd1);
    check("t6_rst_out_data", od0, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_no_stale_valid", 128'(out_valid_v[0]), 128'd0);
    run_block(0, C1, K1, 0, P1, "t6_rerun");

    // Randomised blocks against the reference model
    for (int n = 0; n < 8; n++) begin
      int sel;
      sel  = (n < 6) ? 0 : n - 5;
      rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rct  = {$urandom, $urandom, $urandom, $urandom};
      rks  = expand(rkey, 4 + 2*sel);
      run_block(sel, rct, rkey, int'($urandom_range(0, 3)), ref_dec(rct, rks, 10 + 2*sel),
                $sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
